result_tx_interface: RTL and testbench

//  Return path of the UART calculator: sits downstream of the ALU and upstream of tx_uart.

---
 rtl/result_tx_interface_pkg.sv | 13 +
 rtl/result_fifo.sv | 84 ++++++++
 rtl/result_tx_interface.sv | 89 ++++++++
 tb/tb_result_tx_interface.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_tx_interface_pkg.sv
// Shared definitions for the calculator result return path:
// transmit FSM state encoding and the default result width.
package result_tx_interface_pkg;

   localparam int NB_DATA_DEF = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      START     = 2'b01,
      WAIT_DONE = 2'b10
   } tx_state_e;

endpackage

// File: rtl/result_fifo.sv
// Circular result buffer with registered full/empty flags and a sticky
// overflow flag. A push while full is accepted only if a pop happens alongside.
module result_fifo #(
   parameter int NB_DATA    = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int NB_PTR     = 2
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_push,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_pop,
   output logic [NB_DATA-1:0] o_head,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_overflow
);

   localparam logic [NB_PTR:0] DEPTH_C = (NB_PTR + 1)'(FIFO_DEPTH);

   logic [NB_DATA-1:0] mem_q [FIFO_DEPTH];
   logic [NB_PTR-1:0]  wr_ptr_q, wr_ptr_d;
   logic [NB_PTR-1:0]  rd_ptr_q, rd_ptr_d;
   logic [NB_PTR:0]    count_q, count_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   logic               overflow_q, overflow_d;
   logic               wr_en;

   // When full, the slot at wr_ptr is the head being popped this cycle, so
   // the write may reuse it.
   assign wr_en = i_push && (!full_q || i_pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (i_push && !wr_en);
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (i_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (wr_en && !i_pop) begin
         count_d = count_q + 1'b1;
      end else if (!wr_en && i_pop) begin
         count_d = count_q - 1'b1;
      end
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge i_clock) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   assign o_head     = mem_q[rd_ptr_q];
   assign o_full     = full_q;
   assign o_empty    = empty_q;
   assign o_overflow = overflow_q;

endmodule

// File: rtl/result_tx_interface.sv
// Buffers ALU results and hands them to tx_uart one byte at a time using a
// start pulse / done tick handshake.
module result_tx_interface
   import result_tx_interface_pkg::*;
#(
   parameter int NB_DATA    = NB_DATA_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int NB_PTR     = 2
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic [NB_DATA-1:0] i_result,
   input  logic               i_tx_done_tick,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_overflow
);

   tx_state_e          state_q, state_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic               tx_start_q, tx_start_d;
   logic               pop;
   logic [NB_DATA-1:0] fifo_head;
   logic               fifo_empty;

   result_fifo #(
      .NB_DATA   (NB_DATA),
      .FIFO_DEPTH(FIFO_DEPTH),
      .NB_PTR    (NB_PTR)
   ) u_fifo (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_push    (i_valid),
      .i_data    (i_result),
      .i_pop     (pop),
      .o_head    (fifo_head),
      .o_full    (o_full),
      .o_empty   (fifo_empty),
      .o_overflow(o_overflow)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               data_d  = fifo_head;
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_tx_done_tick) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Registered so the pulse lines up with the START state cycle.
      tx_start_d = (state_d == START);
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= IDLE;
         data_q     <= '0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         tx_start_q <= tx_start_d;
      end
   end

   assign o_tx_start = tx_start_q;
   assign o_data     = data_q;
   assign o_empty    = fifo_empty;

endmodule

// File: tb/tb_result_tx_interface.sv
// Scoreboard bench for result_tx_interface with a queue-based reference model
// and a tx_uart stand-in that answers each start with a done tick 20 cycles later.
module tb_result_tx_interface;

   localparam int DEPTH = 4;

   logic       i_clock = 1'b0;
   logic       i_reset = 1'b0;
   logic       i_valid = 1'b0;
   logic [7:0] i_result = 8'h00;
   logic       i_tx_done_tick = 1'b0;
   logic       o_tx_start;
   logic [7:0] o_data;
   logic       o_full;
   logic       o_empty;
   logic       o_overflow;

   int errors = 0;
   int checks = 0;
   bit stall  = 1'b0;

   always #5 i_clock = ~i_clock;

   result_tx_interface #(
      .NB_DATA   (8),
      .FIFO_DEPTH(DEPTH),
      .NB_PTR    (2)
   ) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_valid       (i_valid),
      .i_result      (i_result),
      .i_tx_done_tick(i_tx_done_tick),
      .o_tx_start    (o_tx_start),
      .o_data        (o_data),
      .o_full        (o_full),
      .o_empty       (o_empty),
      .o_overflow    (o_overflow)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mq holds accepted-but-unsent bytes, m_busy means a byte
   // is owned by the transmitter, m_ann marks the cycle the start is announced.
   logic [7:0] mq[$];
   logic [7:0] sb[$];
   logic [7:0] tx_log[$];
   logic [7:0] expq[$];
   bit         m_busy = 1'b0;
   bit         m_ann  = 1'b0;
   bit         m_ovf  = 1'b0;
   logic [7:0] m_data = 8'h00;

   initial begin
      forever begin
         @(posedge i_clock or negedge i_reset);
         if (!i_reset) begin
            mq.delete();
            sb.delete();
            m_busy = 1'b0;
            m_ann  = 1'b0;
            m_ovf  = 1'b0;
            m_data = 8'h00;
         end else begin : step
            bit pop;
            bit room;
            pop  = !m_busy && (mq.size() > 0);
            room = (mq.size() < DEPTH) || pop;
            if (pop) begin
               m_data = mq.pop_front();
               sb.push_back(m_data);
               m_busy = 1'b1;
               m_ann  = 1'b1;
            end else if (m_ann) begin
               m_ann = 1'b0;
            end else if (m_busy && i_tx_done_tick) begin
               m_busy = 1'b0;
            end
            if (i_valid) begin
               if (room) mq.push_back(i_result);
               else      m_ovf = 1'b1;
            end
         end
      end
   end

   // Monitor: compares every visible output against the model each cycle and
   // pops the scoreboard whenever the DUT issues a start.
   initial begin : monitor
      logic [7:0] exp_b;
      forever begin
         @(negedge i_clock);
         chk("empty", int'(o_empty), int'(mq.size() == 0));
         chk("full", int'(o_full), int'(mq.size() == DEPTH));
         chk("overflow", int'(o_overflow), int'(m_ovf));
         chk("tx_start", int'(o_tx_start), int'(m_ann));
         chk("data_hold", int'(o_data), int'(m_data));
         if (o_tx_start === 1'b1) begin
            tx_log.push_back(o_data);
            if (sb.size() == 0) begin
               chk("sb_unexpected_start", 1, 0);
            end else begin
               exp_b = sb.pop_front();
               chk("sb_data", int'(o_data), int'(exp_b));
            end
         end
      end
   end

   // tx_uart stand-in: done tick 20 cycles after a start; held back while stalled.
   initial begin : tx_model
      int cnt;
      cnt = 0;
      forever begin
         @(posedge i_clock);
         #1;
         i_tx_done_tick = 1'b0;
         if (!i_reset) begin
            cnt = 0;
         end else if (o_tx_start) begin
            cnt = 20;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               if (stall) cnt = 1;
               else       i_tx_done_tick = 1'b1;
            end
         end
      end
   end

   task automatic drive(input logic [7:0] d);
      @(posedge i_clock);
      #1;
      i_valid  = 1'b1;
      i_result = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clock);
         #1;
         i_valid = 1'b0;
      end
   endtask

   task automatic wait_quiet(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!m_busy && !m_ann && mq.size() == 0) begin
            done = 1'b1;
            break;
         end
         @(posedge i_clock);
      end
      chk({name, "_quiet_timeout"}, int'(done), 1);
      idle(3);
   endtask

   task automatic check_log(input string name);
      chk({name, "_count"}, tx_log.size(), expq.size());
      for (int i = 0; i < expq.size() && i < tx_log.size(); i++) begin
         chk($sformatf("%s_byte%0d", name, i), int'(tx_log[i]), int'(expq[i]));
      end
   endtask

   task automatic do_reset(input int n);
      @(posedge i_clock);
      #1;
      i_reset = 1'b0;
      i_valid = 1'b0;
      repeat (n) @(posedge i_clock);
      #1;
      i_reset = 1'b1;
   endtask

   initial begin : stim
      bit seen;
      // Reset held with random valid traffic.
      repeat (10) begin
         @(posedge i_clock);
         #1;
         i_valid  = 1'($urandom_range(0, 1));
         i_result = 8'($urandom);
         chk("rst_tx_start", int'(o_tx_start), 0);
         chk("rst_empty", int'(o_empty), 1);
         chk("rst_data", int'(o_data), 0);
      end
      idle(1);
      i_reset = 1'b1;
      idle(2);

      // Single result.
      tx_log.delete();
      drive(8'h2A);
      idle(1);
      wait_quiet("single");
      expq = {8'h2A};
      check_log("single");

      // Consecutive burst.
      tx_log.delete();
      for (int i = 1; i <= 4; i++) drive(8'(i));
      idle(1);
      wait_quiet("burst");
      expq = {8'h01, 8'h02, 8'h03, 8'h04};
      check_log("burst");

      // Overflow while the transmitter is stalled.
      tx_log.delete();
      stall = 1'b1;
      for (int i = 0; i < 6; i++) drive(8'(8'h10 + i));
      idle(3);
      chk("ovf_full", int'(o_full), 1);
      chk("ovf_sticky", int'(o_overflow), 1);
      stall = 1'b0;
      wait_quiet("ovf");
      expq = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      check_log("ovf");

      // Push on the pop cycle while full.
      do_reset(3);
      tx_log.delete();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) drive(8'(8'h20 + i));
      idle(3);
      chk("pp_full_before", int'(o_full), 1);
      stall = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge i_clock);
         #2;
         if (i_tx_done_tick) begin
            seen = 1'b1;
            break;
         end
      end
      chk("pp_done_seen", int'(seen), 1);
      drive(8'hAA);
      idle(1);
      chk("pp_full_after", int'(o_full), 1);
      chk("pp_no_overflow", int'(o_overflow), 0);
      wait_quiet("pp");
      expq = {8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'hAA};
      check_log("pp");

      // Reset in the middle of a frame with entries queued.
      stall = 1'b1;
      for (int i = 0; i < 4; i++) drive(8'(8'h30 + i));
      idle(5);
      @(posedge i_clock);
      #1;
      i_reset = 1'b0;
      #1;
      chk("midrst_tx_start", int'(o_tx_start), 0);
      chk("midrst_empty", int'(o_empty), 1);
      stall = 1'b0;
      repeat (3) @(posedge i_clock);
      #1;
      i_reset = 1'b1;
      tx_log.delete();
      drive(8'h55);
      idle(1);
      wait_quiet("midrst");
      expq = {8'h55};
      check_log("midrst");

      // Random traffic mixing bursts, gaps and overflow.
      for (int i = 0; i < 1500; i++) begin
         @(posedge i_clock);
         #1;
         i_valid  = ($urandom_range(0, 11) == 0);
         i_result = 8'($urandom);
      end
      idle(1);
      wait_quiet("random");
      chk("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
